alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational 64-bit ALU (3-bit alucontrol, result + zero flag) between two requesters, e.g. the main execute path and an address/branch helper.
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- Drives the ALU operand and control inputs from the granted requester and captures the result into a per-requester response register, held until accepted.
- Keeps per-requester saturating stall counters for performance debug.

Parameters:
- WIDTH, 64, operand/result width (matches ALU).
- CNTW, 16, stall counter width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  3  ALU control code (passed through unmodified)
- req0_a  input  WIDTH  operand a
- req0_b  input  WIDTH  operand b
- rsp0_valid  output  1  response 0 holds a result
- rsp0_ready  input  1  consumer 0 takes the result this cycle
- rsp0_result  output  WIDTH  captured ALU result
- rsp0_zero  output  1  captured ALU zero flag
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero: same as above for requester 1
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_ctrl  output  3  to ALU alucontrol
- alu_result  input  WIDTH  from ALU result
- alu_zero  input  1  from ALU zero
- stall0_cnt  output  CNTW  cycles requester 0 was valid but not granted
- stall1_cnt  output  CNTW  same for requester 1

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - rsp*_valid=0, rsp*_result=0, rsp*_zero=0.
  - last_grant=1, so requester 0 wins the first tie.
  - stall counters=0.
  - Any pending response is discarded; reset overrides all other updates in the same cycle.
- Eligibility:
  - slot_free_i = !rsp_i_valid || rsp_i_ready.
  - elig_i = req_i_valid && slot_free_i.
- Grant (combinational, one-hot or none):
  - Only one eligible: grant it.
  - Both eligible: grant the requester != last_grant.
  - last_grant updates to the granted index only on a grant cycle; otherwise it holds.
- Ready handshake:
  - req_i_ready = grant_i; never asserted without req_i_valid.
  - An operation is consumed on a cycle where req_i_valid && req_i_ready.
  - Requesters must hold op/a/b stable while valid and not ready.
- ALU drive:
  - Granted requester's op/a/b go to alu_ctrl/alu_a/alu_b.
  - With no grant, all three are driven to 0 (no X on ALU inputs).
- Capture:
  - On a grant to i, at the next edge: rsp_i_valid<=1, rsp_i_result<=alu_result, rsp_i_zero<=alu_zero.
  - Request-to-response latency is exactly 1 cycle.
- Drain:
  - rsp_i_valid && rsp_i_ready with no new grant to i: rsp_i_valid<=0, result/zero hold their values.
  - Drain and new grant to i in the same cycle: rsp_i_valid stays 1 and the new result loads. No bubble; throughput of 1 op/cycle per slot.
- Backpressure: while rsp_i_valid && !rsp_i_ready, requester i is ineligible and the other requester may take every cycle.
- Stall counters:
  - stall_i_cnt += 1 on each cycle with req_i_valid && !grant_i.
  - Saturates at all-ones, never wraps.
- Arithmetic/width: ALU op semantics, including signed slt and shift-amount masking, belong to the ALU. This block never modifies op or operands.

Test Plan:
- Single request: req0 op=000 a=5 b=3, rsp0_ready=1 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_result=8, rsp0_zero=0; alu_* return to 0 once idle.
- Zero flag: req1 op=001 a=7 b=7 -> rsp1_result=0, rsp1_zero=1, one cycle after accept.
- Round-robin: both valid continuously, rsp ready=1, out of reset -> grants 0,1,0,1,...; stall counters each increment every other cycle.
- Backpressure: hold rsp0_ready=0 after the first rsp0 -> req0_ready stays 0, req1 granted every cycle, stall0_cnt increments per cycle, rsp0_result stays stable. Release rsp0_ready -> req0 granted the same cycle.
- Same-cycle drain and reload: rsp0_valid=1, rsp0_ready=1, req0 op=011 a=0xF0 b=0x0F -> rsp0_valid remains 1, result becomes 0xFF next cycle.
- Saturation/reset: force stall0_cnt to 0xFFFF and keep req0 stalled -> counter stays 0xFFFF. Assert reset with responses pending -> all rsp_valid=0, counters=0, next tie goes to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one combinational ALU between two requesters with round-robin arbitration.
// Latency : a granted request produces its response exactly 1 cycle later (registered capture).
// Backpressure: a requester is only eligible when its response slot is empty or being drained
//               this cycle; a stalled response blocks only its own requester.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   reqN_valid/ready/op/a/b     request side handshake and ALU operation (N = 0, 1)
//   rspN_valid/ready/result/zero response side handshake and captured ALU outputs
//   alu_a/alu_b/alu_ctrl        drive to the shared ALU (zero when nothing is granted)
//   alu_result/alu_zero         combinational return from the shared ALU
//   stallN_cnt                  saturating count of cycles requester N was valid but not granted
module alu_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic [CNTW-1:0]  stall0_cnt,
    output logic [CNTW-1:0]  stall1_cnt
);

    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic             rsp0_zero_q, rsp0_zero_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp1_zero_q, rsp1_zero_d;
    logic             last_grant_q, last_grant_d;
    logic [CNTW-1:0]  stall0_cnt_q, stall0_cnt_d;
    logic [CNTW-1:0]  stall1_cnt_q, stall1_cnt_d;

    logic elig0, elig1;
    logic grant0, grant1;

    // A slot that is being drained this cycle can be refilled in the same cycle,
    // so a continuously-ready consumer sees one result per cycle with no bubble.
    assign elig0 = req0_valid && (!rsp0_valid_q || rsp0_ready);
    assign elig1 = req1_valid && (!rsp1_valid_q || rsp1_ready);

    // On a tie the requester that did not win last time gets the ALU.
    assign grant0 = elig0 && (!elig1 || last_grant_q);
    assign grant1 = elig1 && (!elig0 || !last_grant_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Idle ALU inputs are forced to zero so the ALU never sees X.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 3'b000;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_op;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_op;
        end
    end

    always_comb begin
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d  = 1'b0;
        end

        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d  = 1'b0;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    // Stall counters stick at all-ones so a long stall is never misread as a short one.
    always_comb begin
        stall0_cnt_d = stall0_cnt_q;
        if (req0_valid && !grant0 && (stall0_cnt_q != '1)) begin
            stall0_cnt_d = stall0_cnt_q + CNTW'(1);
        end
        stall1_cnt_d = stall1_cnt_q;
        if (req1_valid && !grant1 && (stall1_cnt_q != '1)) begin
            stall1_cnt_d = stall1_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
            last_grant_q  <= 1'b1;
            stall0_cnt_q  <= '0;
            stall1_cnt_q  <= '0;
        end else begin
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
            last_grant_q  <= last_grant_d;
            stall0_cnt_q  <= stall0_cnt_d;
            stall1_cnt_q  <= stall1_cnt_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;
    assign stall0_cnt  = stall0_cnt_q;
    assign stall1_cnt  = stall1_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : self-checking bench for alu_share_arbiter with a behavioural ALU and reference model.
// Latency : checks responses one cycle after each grant.
// Backpressure: randomises consumer ready and holds requests stable until accepted.
module tb_alu_share_arbiter;

    localparam int W    = 64;
    localparam int CW   = 6;
    localparam logic [CW-1:0] CMAX = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          in_v   [2];
    logic [2:0]    in_op  [2];
    logic [W-1:0]  in_a   [2];
    logic [W-1:0]  in_b   [2];
    logic          in_rdy [2];

    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
    logic [W-1:0]  rsp0_result, rsp1_result;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [2:0]    alu_ctrl;
    logic          alu_zero;
    logic [CW-1:0] stall0_cnt, stall1_cnt;

    alu_share_arbiter #(.WIDTH(W), .CNTW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(in_v[0]), .req0_ready(req0_ready), .req0_op(in_op[0]),
        .req0_a(in_a[0]), .req0_b(in_b[0]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(in_rdy[0]),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(in_v[1]), .req1_ready(req1_ready), .req1_op(in_op[1]),
        .req1_a(in_a[1]), .req1_b(in_b[1]),
        .rsp1_valid(rsp1_valid), .rsp1_ready(in_rdy[1]),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd6:    return a << b[5:0];
            default: return a >> b[5:0];
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: what each response slot holds and who won last.
    int           m_last;
    logic         m_rv [2];
    logic [W-1:0] m_rr [2];
    logic         m_rz [2];
    int           m_sc [2];
    int           mg;

    task automatic model_reset();
        m_last = 1;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0; m_rr[i] = '0; m_rz[i] = 1'b0; m_sc[i] = 0;
        end
    endtask

    // Called just after a rising edge with inputs already applied; returns after the next edge.
    task automatic cycle();
        bit e [2];
        logic [W-1:0] ea, eb;
        logic [2:0] ec;
        #1;
        for (int i = 0; i < 2; i++) e[i] = in_v[i] && (!m_rv[i] || in_rdy[i]);
        if (e[0] && e[1]) mg = 1 - m_last;
        else if (e[0])    mg = 0;
        else if (e[1])    mg = 1;
        else              mg = -1;
        ea = '0; eb = '0; ec = 3'd0;
        if (mg >= 0) begin ea = in_a[mg]; eb = in_b[mg]; ec = in_op[mg]; end
        chk("req0_ready", req0_ready, mg == 0);
        chk("req1_ready", req1_ready, mg == 1);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_ctrl", alu_ctrl, ec);
        chk("rsp0_valid", rsp0_valid, m_rv[0]);
        chk("rsp1_valid", rsp1_valid, m_rv[1]);
        chk("rsp0_result", rsp0_result, m_rr[0]);
        chk("rsp1_result", rsp1_result, m_rr[1]);
        chk("rsp0_zero", rsp0_zero, m_rz[0]);
        chk("rsp1_zero", rsp1_zero, m_rz[1]);
        chk("stall0_cnt", stall0_cnt, m_sc[0]);
        chk("stall1_cnt", stall1_cnt, m_sc[1]);
        @(posedge clk);
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mg == i) begin
                    m_rv[i] = 1'b1;
                    m_rr[i] = alu_fn(in_op[i], in_a[i], in_b[i]);
                    m_rz[i] = (m_rr[i] == '0);
                end else if (m_rv[i] && in_rdy[i]) begin
                    m_rv[i] = 1'b0;
                end
                if (in_v[i] && mg != i && m_sc[i] < int'(CMAX)) m_sc[i]++;
            end
            if (mg >= 0) m_last = mg;
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        in_v[i] = v; in_op[i] = op; in_a[i] = a; in_b[i] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_req(0, 1'b0, 3'd0, '0, '0);
        set_req(1, 1'b0, 3'd0, '0, '0);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 1'b0, 3'd0, '0, '0);
            in_rdy[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_rsp0_result", rsp0_result, 64'd0);
        chk("rst_stall0", stall0_cnt, 64'd0);
        chk("rst_stall1", stall1_cnt, 64'd0);

        // Single request: 5 + 3.
        set_req(0, 1'b1, 3'b000, 64'd5, 64'd3);
        #1;
        chk("single_ready", req0_ready, 1'b1);
        chk("single_alu_a", alu_a, 64'd5);
        cycle();
        set_req(0, 1'b0, 3'b000, '0, '0);
        chk("single_valid", rsp0_valid, 1'b1);
        chk("single_result", rsp0_result, 64'd8);
        chk("single_zero", rsp0_zero, 1'b0);
        #1;
        chk("idle_alu_a", alu_a, 64'd0);
        chk("idle_alu_ctrl", alu_ctrl, 64'd0);
        cycle();
        chk("single_drained", rsp0_valid, 1'b0);

        // Zero flag on requester 1: 7 - 7.
        set_req(1, 1'b1, 3'b001, 64'd7, 64'd7);
        cycle();
        set_req(1, 1'b0, 3'b000, '0, '0);
        chk("zero_valid", rsp1_valid, 1'b1);
        chk("zero_result", rsp1_result, 64'd0);
        chk("zero_flag", rsp1_zero, 1'b1);

        // Round robin from reset: grants alternate starting with requester 0.
        do_reset();
        set_req(0, 1'b1, 3'b000, 64'h10, 64'h20);
        set_req(1, 1'b1, 3'b010, 64'hFF, 64'h0F);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant0", req0_ready, (k % 2) == 0);
            cycle();
        end
        chk("rr_stall0", stall0_cnt, 64'd3);
        chk("rr_stall1", stall1_cnt, 64'd3);

        // Backpressure on response 0.
        in_rdy[0] = 1'b0;
        #1;
        chk("bp_first_grant0", req0_ready, 1'b1);
        cycle();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_ready0", req0_ready, 1'b0);
            chk("bp_ready1", req1_ready, 1'b1);
            cycle();
            chk("bp_hold_result", rsp0_result, 64'h30);
        end
        chk("bp_stall0", stall0_cnt, 64'd7);
        chk("bp_stall1", stall1_cnt, 64'd4);
        in_rdy[0] = 1'b1;
        #1;
        chk("bp_release_grant0", req0_ready, 1'b1);
        cycle();

        // Same-cycle drain and reload.
        set_req(0, 1'b1, 3'b011, 64'hF0, 64'h0F);
        set_req(1, 1'b0, 3'b000, '0, '0);
        chk("reload_pre_valid", rsp0_valid, 1'b1);
        cycle();
        set_req(0, 1'b0, 3'b000, '0, '0);
        chk("reload_valid", rsp0_valid, 1'b1);
        chk("reload_result", rsp0_result, 64'hFF);

        // Saturation of the stall counter.
        do_reset();
        set_req(0, 1'b1, 3'b100, 64'h3, 64'h5);
        set_req(1, 1'b1, 3'b000, 64'h1, 64'h1);
        in_rdy[0] = 1'b0;
        repeat (80) cycle();
        chk("sat_stall0", stall0_cnt, 64'(CMAX));
        chk("sat_stall1", stall1_cnt, 64'd1);
        chk("sat_rsp0_result", rsp0_result, 64'h6);

        // Reset with both responses pending.
        do_reset();
        chk("rstp_rsp0_valid", rsp0_valid, 1'b0);
        chk("rstp_rsp1_valid", rsp1_valid, 1'b0);
        chk("rstp_rsp0_result", rsp0_result, 64'd0);
        chk("rstp_stall0", stall0_cnt, 64'd0);
        in_rdy[0] = 1'b1;
        in_rdy[1] = 1'b1;
        set_req(0, 1'b1, 3'b000, 64'h2, 64'h2);
        set_req(1, 1'b1, 3'b000, 64'h4, 64'h4);
        #1;
        chk("rstp_tie_grant0", req0_ready, 1'b1);
        chk("rstp_tie_grant1", req1_ready, 1'b0);
        cycle();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!in_v[i] || mg == i) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    ra = {$urandom, $urandom};
                    rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
                    set_req(i, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb);
                end
                in_rdy[i] = $urandom_range(0, 3) != 0;
            end
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
